// File: rtl/qpu_ifu_imem_arb.sv
// qpu_ifu_imem_arb: shares one single-port instruction SRAM between the IFU
// fetch port and the program loader. Each requester owns a 2-entry response
// FIFO; a credit check (FIFO occupancy + in-flight access) gates its grant,
// so the FIFO can never overflow.
// Optional build macro: QPU_IMEM_ARB_RR_EN selects round-robin arbitration;
// without it the loader always wins on contention.
`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif
`ifndef QPU_INSTR_SIZE
`define QPU_INSTR_SIZE 32
`endif

module qpu_ifu_imem_arb (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ifu_req_valid,
  output logic                        ifu_req_ready,
  input  logic [`QPU_PC_SIZE-1:0]     ifu_req_pc,
  output logic                        ifu_rsp_valid,
  input  logic                        ifu_rsp_ready,
  output logic [`QPU_INSTR_SIZE-1:0]  ifu_rsp_instr,
  input  logic                        ld_req_valid,
  output logic                        ld_req_ready,
  input  logic                        ld_req_we,
  input  logic [`QPU_PC_SIZE-1:0]     ld_req_addr,
  input  logic [`QPU_INSTR_SIZE-1:0]  ld_req_wdata,
  output logic                        ld_rsp_valid,
  input  logic                        ld_rsp_ready,
  output logic [`QPU_INSTR_SIZE-1:0]  ld_rsp_rdata,
  output logic                        imem_cs,
  output logic                        imem_we,
  output logic [`QPU_PC_SIZE-3:0]     imem_addr,
  output logic [`QPU_INSTR_SIZE-1:0]  imem_wdata,
  input  logic [`QPU_INSTR_SIZE-1:0]  imem_rdata
);

  localparam int PW = `QPU_PC_SIZE;
  localparam int IW = `QPU_INSTR_SIZE;

  // Index 0 = IFU, index 1 = loader throughout.
  logic [1:0]    req_valid, rsp_ready, eligible, grant;
  logic [1:0]    infl, fifo_ne, pop, push, rsp_valid;
  logic          infl_wr;
  logic [1:0]    cnt     [2];
  logic [1:0]    cnt_nxt [2];
  logic          rd_ptr  [2];
  logic          wr_idx  [2];
  logic [IW-1:0] mem     [2][2];
  logic [IW-1:0] byp_data[2];
  logic [IW-1:0] rsp_data[2];

  assign req_valid = {ld_req_valid, ifu_req_valid};
  assign rsp_ready = {ld_rsp_ready, ifu_rsp_ready};

  // Credit check uses registered state only, so ready never depends on rsp side.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      eligible[r] = req_valid[r] & ((cnt[r] == 2'd0) | ((cnt[r] == 2'd1) & ~infl[r]));
      fifo_ne[r]  = (cnt[r] != 2'd0);
      wr_idx[r]   = rd_ptr[r] ^ cnt[r][0];
      byp_data[r] = ((r == 1) && infl_wr) ? '0 : imem_rdata;
      rsp_valid[r] = ~rst & (fifo_ne[r] | infl[r]);
      rsp_data[r]  = ~rsp_valid[r] ? '0 : (fifo_ne[r] ? mem[r][rd_ptr[r]] : byp_data[r]);
      pop[r]  = ~rst & fifo_ne[r] & rsp_ready[r];
      // Bypass data is consumed only when nothing is queued ahead of it.
      push[r] = ~rst & infl[r] & (fifo_ne[r] | ~rsp_ready[r]);
      cnt_nxt[r] = cnt[r];
      if (push[r] && !pop[r])      cnt_nxt[r] = cnt[r] + 2'd1;
      else if (!push[r] && pop[r]) cnt_nxt[r] = cnt[r] - 2'd1;
    end
  end

`ifdef QPU_IMEM_ARB_RR_EN
  logic pref_ifu;

  // Round-robin grant: on contention, favour the requester not granted last.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (eligible == 2'b11) grant = pref_ifu ? 2'b01 : 2'b10;
      else                   grant = eligible;
    end
  end

  // Pointer moves only when someone is granted.
  always_ff @(posedge clk) begin
    if (rst)           pref_ifu <= 1'b1;
    else if (grant[0]) pref_ifu <= 1'b0;
    else if (grant[1]) pref_ifu <= 1'b1;
  end
`else
  // Fixed priority grant: loader always beats the IFU.
  always_comb begin
    grant = 2'b00;
    if (!rst) grant = eligible[1] ? 2'b10 : eligible;
  end
`endif

  assign ifu_req_ready = grant[0];
  assign ld_req_ready  = grant[1];
  assign ifu_rsp_valid = rsp_valid[0];
  assign ld_rsp_valid  = rsp_valid[1];
  assign ifu_rsp_instr = rsp_data[0];
  assign ld_rsp_rdata  = rsp_data[1];

  // SRAM port: driven only in the cycle a request handshakes.
  always_comb begin
    imem_cs    = |grant;
    imem_we    = grant[1] & ld_req_we;
    imem_addr  = '0;
    imem_wdata = '0;
    if (grant[1]) begin
      imem_addr  = ld_req_addr[PW-1:2];
      imem_wdata = ld_req_wdata;
    end else if (grant[0]) begin
      imem_addr  = ifu_req_pc[PW-1:2];
    end
  end

  // In-flight flags and FIFO pointers; reset drops every pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl    <= 2'b00;
      infl_wr <= 1'b0;
      for (int r = 0; r < 2; r++) begin
        cnt[r]    <= 2'd0;
        rd_ptr[r] <= 1'b0;
      end
    end else begin
      infl    <= grant;
      infl_wr <= grant[1] & ld_req_we;
      for (int r = 0; r < 2; r++) begin
        cnt[r] <= cnt_nxt[r];
        if (pop[r]) rd_ptr[r] <= ~rd_ptr[r];
      end
    end
  end

  // FIFO storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) mem[r][wr_idx[r]] <= byp_data[r];
    end
  end

endmodule

// File: doc/qpu_ifu_imem_arb.md
QPU_IFU_IMEM_ARB -- requirements
Module: qpu_ifu_imem_arb

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 ifu_req_valid/ifu_req_ready  input/output  1/1  IFU fetch request handshake.
REQ-004 ifu_req_pc  input  `QPU_PC_SIZE  fetch byte address; word index = pc[`QPU_PC_SIZE-1:2], bits [1:0] ignored.
REQ-005 ifu_rsp_valid/ifu_rsp_ready  output/input  1/1  IFU response handshake; ifu_rsp_instr  output  `QPU_INSTR_SIZE  fetched word.
REQ-006 ld_req_valid/ld_req_ready  input/output  1/1  loader request handshake; ld_req_we  input  1  write=1, read=0.
REQ-007 ld_req_addr  input  `QPU_PC_SIZE  byte address, bits [1:0] ignored; ld_req_wdata  input  `QPU_INSTR_SIZE  write data.
REQ-008 ld_rsp_valid/ld_rsp_ready  output/input  1/1  loader response handshake; ld_rsp_rdata  output  `QPU_INSTR_SIZE  read data (0 for write acks).
REQ-009 imem_cs, imem_we  output  1  single-port SRAM select/write; imem_addr  output  `QPU_PC_SIZE-2; imem_wdata  output  `QPU_INSTR_SIZE; imem_rdata  input  `QPU_INSTR_SIZE, valid cycle after cs&~we.

Function
REQ-010 At most one SRAM access per cycle; imem_cs=1 exactly in cycles where a request handshakes.
REQ-011 Requester X eligible when X_req_valid=1 and credit_X<2, credit_X = rsp-FIFO occupancy + in-flight access of X (a same-cycle rsp handshake does not free credit).
REQ-012 Grant: one eligible -> it wins; both eligible -> arbitration policy (REQ-026/027); X_req_ready = grant_X.
REQ-013 X_req_ready shall not depend combinationally on X_rsp_ready or either rsp_valid.
REQ-014 Granted cycle N: imem_addr = word index, imem_we = ld_req_we for loader else 0, imem_wdata = ld_req_wdata.
REQ-015 Every handshaked request (read or write) produces exactly one response, in request order per requester.
REQ-016 Response latency: X_rsp_valid=1 in cycle N+1 at earliest; FIFO empty -> data = imem_rdata (bypass), loader write -> 0.
REQ-017 Response not accepted in its first cycle -> pushed into X's 2-entry FIFO; rsp_valid = FIFO non-empty | bypass valid; data = FIFO head when non-empty.
REQ-018 rsp_valid and data stable until handshake; push and pop in same cycle keep occupancy.
REQ-019 Credit limit guarantees no FIFO overflow; back-to-back reads from one requester sustain 1 response/cycle when rsp_ready held 1.
REQ-020 Loader write then IFU read of same word, granted in that order -> IFU sees new data.
REQ-021 ifu_req_pc bits [1:0] nonzero: access proceeds on truncated word index, no error.

Reset
REQ-022 While rst=1: all FIFOs empty, in-flight flags 0, arbitration pointer = IFU-preferred.
REQ-023 Reset values: ifu_req_ready=0, ld_req_ready=0, ifu_rsp_valid=0, ld_rsp_valid=0, imem_cs=0, imem_we=0, data outputs 0.
REQ-024 rst asserted mid-operation: pending/buffered responses discarded, never presented after rst deasserts.
REQ-025 First grant possible in first cycle with rst=0.

Configuration
REQ-026 QPU_IMEM_ARB_RR_EN defined: round-robin; on contention grant the requester not granted last; pointer updates only on a grant.
REQ-027 QPU_IMEM_ARB_RR_EN undefined: fixed priority, loader always beats IFU; no pointer state.

Verification
REQ-028 Reset: rst=1 3 cycles, both valids 1 -> all readys/valids/imem_cs 0; cycle after release ifu_req_ready=1 (RR) or ld_req_ready=1 (fixed).
REQ-029 Loader writes 0xDEAD_BEEF @0x40, then IFU reads pc=0x42 -> ld_rsp rdata 0, ifu_rsp_instr=0xDEAD_BEEF at N+1.
REQ-030 IFU streams pc 0x0,0x4,0x8 with ifu_rsp_ready=1 -> one response per cycle, in order, latency 1.
REQ-031 ifu_rsp_ready=0 for 4 cycles, ifu_req_valid=1 -> exactly 2 accepted, ifu_req_ready then 0, responses drain in order on ready=1.
REQ-032 Both valid continuously 6 cycles -> RR: grants alternate IFU,LD,IFU...; fixed: loader all 6.
REQ-033 rst pulsed 1 cycle with 2 buffered IFU responses -> ifu_rsp_valid=0 afterwards, no stale data.
